// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider.
// Op codes, FSM states and op-code decode helpers.
package div_unit_pkg;

   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   // Signed ops; undefined codes fall back to unsigned divide
   function automatic logic op_signed(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Remainder ops; undefined codes fall back to quotient
   function automatic logic op_rem(input logic [2:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift/compare/subtract iteration.
// Register layout: {remainder, dividend/quotient}.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] i_rq,
   input  logic [XLEN-1:0]   i_div,
   output logic [2*XLEN-1:0] o_rq
);

   logic [2*XLEN:0] w_sh;
   logic [XLEN+1:0] w_diff;

   assign w_sh   = {i_rq, 1'b0};
   // Extra top bit keeps the bit shifted out of the remainder
   assign w_diff = {1'b0, w_sh[2*XLEN:XLEN]} - {2'b00, i_div};

   // Subtract when it fits and set the new quotient bit
   always_comb begin
      o_rq = w_sh[2*XLEN-1:0];
      if (!w_diff[XLEN+1])
         o_rq = {w_diff[XLEN-1:0], w_sh[XLEN-1:1], 1'b1};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Fixed XLEN+1 cycle latency; divide-by-zero and overflow exit early.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [XLEN-1:0]    div_data1_i,
   input  logic [XLEN-1:0]    div_data2_i,
   input  logic [2:0]         div_op_code_i,
   input  logic               div_req_i,
   input  logic               div_kill_i,
   input  logic [RADDR_W-1:0] div_reg_wr_addr_i,
   output logic               div_busy_o,
   output logic               div_res_ready_o,
   output logic [XLEN-1:0]    div_res_o,
   output logic [RADDR_W-1:0] div_reg_wr_addr_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] LAST = CW'(XLEN);

   div_state_e r_state, w_next;

   logic [CW-1:0]      r_cnt;
   logic [2*XLEN-1:0]  r_rq;
   logic [2*XLEN-1:0]  w_rq_step;
   logic [XLEN-1:0]    r_div, r_a, r_res;
   logic [XLEN-1:0]    w_res, w_a_abs, w_b_abs, w_q, w_r;
   logic [2:0]         r_op;
   logic [RADDR_W-1:0] r_addr;
   logic               r_neg_q, r_neg_r, r_dvz, r_ovf;
   logic               w_sgn, w_accept, w_min, w_fin;

   assign w_sgn    = op_signed(div_op_code_i);
   assign w_accept = (r_state == S_IDLE) && div_req_i && !div_kill_i;
   assign w_min    = div_data1_i == {1'b1, {(XLEN-1){1'b0}}};
   assign w_a_abs  = (w_sgn && div_data1_i[XLEN-1]) ? -div_data1_i
                                                   : div_data1_i;
   assign w_b_abs  = (w_sgn && div_data2_i[XLEN-1]) ? -div_data2_i
                                                   : div_data2_i;
   assign w_q      = r_rq[XLEN-1:0];
   assign w_r      = r_rq[2*XLEN-1:XLEN];

   div_step #(.XLEN(XLEN)) u_step (
      .i_rq  (r_rq),
      .i_div (r_div),
      .o_rq  (w_rq_step)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state; w_fin marks the edge that latches the result
   always_comb begin
      w_next = r_state;
      w_fin  = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_CALC;
         S_CALC: begin
            if (div_kill_i) begin
               w_next = S_IDLE;
            end else if (r_dvz || r_ovf || r_cnt == LAST) begin
               w_next = S_DONE;
               w_fin  = 1'b1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Final result: early-out constants or sign-fixed magnitudes
   always_comb begin
      w_res = w_q;
      if (r_dvz)
         w_res = op_rem(r_op) ? r_a : {XLEN{1'b1}};
      else if (r_ovf)
         w_res = op_rem(r_op) ? {XLEN{1'b0}} : r_a;
      else if (op_rem(r_op))
         w_res = r_neg_r ? -w_r : w_r;
      else
         w_res = r_neg_q ? -w_q : w_q;
   end

   // Operand capture, iteration and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_rq    <= '0;
         r_div   <= '0;
         r_a     <= '0;
         r_res   <= '0;
         r_op    <= '0;
         r_addr  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dvz   <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_rq    <= {{XLEN{1'b0}}, w_a_abs};
         r_div   <= w_b_abs;
         r_a     <= div_data1_i;
         r_op    <= div_op_code_i;
         r_addr  <= div_reg_wr_addr_i;
         r_neg_q <= w_sgn && (div_data1_i[XLEN-1] ^ div_data2_i[XLEN-1]);
         r_neg_r <= w_sgn && div_data1_i[XLEN-1];
         r_dvz   <= div_data2_i == '0;
         r_ovf   <= w_sgn && w_min && (&div_data2_i);
      end else if (r_state == S_CALC && !div_kill_i) begin
         if (w_fin) begin
            r_res <= w_res;
         end else begin
            r_rq  <= w_rq_step;
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign div_busy_o        = r_state != S_IDLE;
   assign div_res_ready_o   = (r_state == S_DONE) && !div_kill_i;
   assign div_res_o         = r_res;
   assign div_reg_wr_addr_o = r_addr;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table on a 32-bit build,
// kill/reset corner sequences and a 64-bit build.
module tb_div_unit;

   localparam logic [2:0] DIV  = 3'b100;
   localparam logic [2:0] DIVU = 3'b101;
   localparam logic [2:0] REM  = 3'b110;
   localparam logic [2:0] REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] a = '0, b = '0;
   logic [2:0]  op = '0;
   logic [4:0]  addr = '0;
   logic        req32 = 1'b0, req64 = 1'b0, kill = 1'b0;

   logic        busy32, rdy32, busy64, rdy64;
   logic [31:0] res32;
   logic [63:0] res64;
   logic [4:0]  ad32, ad64;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   div_unit #(.XLEN(32), .RADDR_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .div_data1_i(a[31:0]), .div_data2_i(b[31:0]),
      .div_op_code_i(op), .div_req_i(req32), .div_kill_i(kill),
      .div_reg_wr_addr_i(addr),
      .div_busy_o(busy32), .div_res_ready_o(rdy32),
      .div_res_o(res32), .div_reg_wr_addr_o(ad32)
   );

   div_unit #(.XLEN(64), .RADDR_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .div_data1_i(a), .div_data2_i(b),
      .div_op_code_i(op), .div_req_i(req64), .div_kill_i(kill),
      .div_reg_wr_addr_i(addr),
      .div_busy_o(busy64), .div_res_ready_o(rdy64),
      .div_res_o(res64), .div_reg_wr_addr_o(ad64)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vt[18];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue at the current negedge; count cycles after E0 until ready
   task automatic run_op(input bit w64, input logic [2:0] o,
                         input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] ad, input logic [63:0] exp,
                         input int lat, input string name);
      int  n;
      bit  seen;
      op = o; a = x; b = y; addr = ad;
      if (w64) req64 = 1'b1;
      else     req32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req32 = 1'b0;
      req64 = 1'b0;
      n = 0;
      seen = 1'b0;
      while (n <= 200 && !seen) begin
         if (w64 ? rdy64 : rdy32) begin
            seen = 1'b1;
         end else begin
            @(posedge clk);
            @(negedge clk);
            n++;
         end
      end
      check({name, " ready seen"}, 64'(seen), 64'd1);
      check({name, " latency"}, 64'(n), 64'(lat));
      check({name, " result"}, w64 ? res64 : {32'b0, res32}, exp);
      check({name, " addr"}, 64'(w64 ? ad64 : ad32), 64'(ad));
      @(posedge clk);
      @(negedge clk);
      check({name, " ready one cycle"}, 64'(w64 ? rdy64 : rdy32), 64'd0);
      check({name, " busy dropped"}, 64'(w64 ? busy64 : busy32), 64'd0);
   endtask

   initial begin
      vt[0]  = '{DIVU, 32'd100,        32'd7,        32'd14,         33};
      vt[1]  = '{REMU, 32'd100,        32'd7,        32'd2,          33};
      vt[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   33};
      vt[3]  = '{REM,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   33};
      vt[4]  = '{DIV,  32'd5,          32'd0,        32'hFFFFFFFF,   1};
      vt[5]  = '{DIVU, 32'd5,          32'd0,        32'hFFFFFFFF,   1};
      vt[6]  = '{REM,  32'h12345678,   32'd0,        32'h12345678,   1};
      vt[7]  = '{REMU, 32'h12345678,   32'd0,        32'h12345678,   1};
      vt[8]  = '{DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000,   1};
      vt[9]  = '{REM,  32'h80000000,   32'hFFFFFFFF, 32'd0,          1};
      vt[10] = '{DIVU, 32'h80000000,   32'hFFFFFFFF, 32'd0,          33};
      vt[11] = '{DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   33};
      vt[12] = '{REM,  32'd7,          32'hFFFFFFFE, 32'd1,          33};
      vt[13] = '{REM,  32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF,   33};
      vt[14] = '{DIVU, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   33};
      vt[15] = '{3'b000, 32'd100,      32'd7,        32'd14,         33};
      vt[16] = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC,   33};
      vt[17] = '{REM,  32'h80000000,   32'd3,        32'hFFFFFFFE,   33};

      // Reset state
      #1;
      check("rst busy", 64'(busy32), 64'd0);
      check("rst ready", 64'(rdy32), 64'd0);
      check("rst res", 64'(res32), 64'd0);
      check("rst addr", 64'(ad32), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table, issued back-to-back
      for (int i = 0; i < 18; i++)
         run_op(1'b0, vt[i].op, 64'(vt[i].a), 64'(vt[i].b), 5'(i),
                64'(vt[i].res), vt[i].lat, $sformatf("vec%0d", i));

      // Kill during CALC at step 10
      begin
         bit any;
         op = DIVU; a = 64'd100; b = 64'd7; req32 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         req32 = 1'b0;
         repeat (10) @(posedge clk);
         @(negedge clk);
         kill = 1'b1;
         @(posedge clk);
         @(negedge clk);
         kill = 1'b0;
         check("kill busy low", 64'(busy32), 64'd0);
         any = 1'b0;
         for (int k = 0; k < 40; k++) begin
            if (rdy32) any = 1'b1;
            @(negedge clk);
         end
         check("kill no ready", 64'(any), 64'd0);
      end
      run_op(1'b0, DIVU, 64'd9, 64'd3, 5'd3, 64'd3, 33, "after kill");

      // Kill together with request in IDLE
      op = DIVU; a = 64'd9; b = 64'd3; req32 = 1'b1; kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req32 = 1'b0; kill = 1'b0;
      check("req+kill no start", 64'(busy32), 64'd0);

      // Kill in DONE suppresses the pulse
      op = DIV; a = 64'd5; b = 64'd0; req32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req32 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("done reached", 64'(rdy32), 64'd1);
      kill = 1'b1;
      #1;
      check("done kill ready", 64'(rdy32), 64'd0);
      @(posedge clk);
      @(negedge clk);
      kill = 1'b0;
      check("done kill busy", 64'(busy32), 64'd0);

      // 64-bit build
      run_op(1'b1, DIVU, 64'h8000000000000000, 64'd3, 5'd7,
             64'h2AAAAAAAAAAAAAAA, 65, "x64 divu");

      // Asynchronous reset mid-CALC
      op = DIVU; a = 64'd100; b = 64'd7; addr = 5'd9; req64 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req64 = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("x64 rst busy", 64'(busy64), 64'd0);
      check("x64 rst ready", 64'(rdy64), 64'd0);
      check("x64 rst res", res64, 64'd0);
      check("x64 rst addr", 64'(ad64), 64'd0);
      check("x32 rst res", 64'(res32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b1, DIVU, 64'd100, 64'd7, 5'd4, 64'd14, 65, "x64 post rst");

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
